// File: rtl/rotator_pkg.sv
// Shared constants and arithmetic helpers for the rotator pipeline.
// Build option: define ROTATOR_SATURATE_EN to clamp overflowing sums instead of wrapping.
package rotator_pkg;

`ifdef ROTATOR_SATURATE_EN
  localparam bit SATURATE = 1'b1;
`else
  localparam bit SATURATE = 1'b0;
`endif

  // Q1.15 cos/sin of 2^-idx rad, idx 0..15 (cos clipped to 32767).
  function automatic int cos_q15(input int idx);
    int r;
    case (idx)
      0:       r = 17705;
      1:       r = 28757;
      2:       r = 31749;
      3:       r = 32512;
      4:       r = 32704;
      5:       r = 32752;
      6:       r = 32764;
      default: r = 32767;
    endcase
    return r;
  endfunction

  function automatic int sin_q15(input int idx);
    int r;
    case (idx)
      0:       r = 27573;
      1:       r = 15710;
      2:       r = 8107;
      3:       r = 4085;
      4:       r = 2047;
      5:       r = 1024;
      6:       r = 512;
      7:       r = 256;
      8:       r = 128;
      9:       r = 64;
      10:      r = 32;
      11:      r = 16;
      12:      r = 8;
      13:      r = 4;
      14:      r = 2;
      15:      r = 1;
      default: r = 0;
    endcase
    return r;
  endfunction

  // Rescale a Q1.15 entry to Q1.(w-1): round half up, clip to the largest positive code.
  function automatic int rescale_coef(input int e, input int w);
    int r;
    if (w >= 16) r = e;
    else         r = (e + (1 <<< (15 - w))) >>> (16 - w);
    if (r > (1 <<< (w - 1)) - 1) r = (1 <<< (w - 1)) - 1;
    return r;
  endfunction

  function automatic int round_prod(input int p, input int sh);
    return (p + (1 <<< (sh - 1))) >>> sh;
  endfunction

  function automatic bit out_of_range(input int v, input int w);
    return (v > (1 <<< (w - 1)) - 1) || (v < -(1 <<< (w - 1)));
  endfunction

  // Clamp when saturating; otherwise the caller's width cast performs the wrap.
  function automatic int fit_sum(input int v, input int w);
    int r;
    r = v;
    if (SATURATE) begin
      if (v > (1 <<< (w - 1)) - 1) r = (1 <<< (w - 1)) - 1;
      else if (v < -(1 <<< (w - 1))) r = -(1 <<< (w - 1));
    end
    return r;
  endfunction

endpackage

// File: rtl/rotator_stage.sv
// One registered rotation stage: rotates by a fixed weight 2^-STAGE rad when rot is set.
// Overflow handling follows ROTATOR_SATURATE_EN through rotator_pkg.
module rotator_stage
  import rotator_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STAGE = 0
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    en,
  input  logic                    vld,
  input  logic                    rot,
  input  logic signed [WIDTH-1:0] x,
  input  logic signed [WIDTH-1:0] y,
  input  logic                    ovf,
  output logic                    vld_q,
  output logic signed [WIDTH-1:0] x_q,
  output logic signed [WIDTH-1:0] y_q,
  output logic                    ovf_q
);

  localparam int C = rescale_coef(cos_q15(STAGE), WIDTH);
  localparam int S = rescale_coef(sin_q15(STAGE), WIDTH);

  int  xc, ys, xs, yc, sum_x, sum_y;
  logic ovf_now;

  always_comb begin
    xc      = round_prod(int'(x) * C, WIDTH - 1);
    ys      = round_prod(int'(y) * S, WIDTH - 1);
    xs      = round_prod(int'(x) * S, WIDTH - 1);
    yc      = round_prod(int'(y) * C, WIDTH - 1);
    sum_x   = xc - ys;
    sum_y   = xs + yc;
    ovf_now = out_of_range(sum_x, WIDTH) || out_of_range(sum_y, WIDTH);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      vld_q <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
      ovf_q <= 1'b0;
    end else if (en) begin
      vld_q <= vld;
      if (vld) begin
        if (rot) begin
          x_q   <= WIDTH'(fit_sum(sum_x, WIDTH));
          y_q   <= WIDTH'(fit_sum(sum_y, WIDTH));
          ovf_q <= ovf | ovf_now;
        end else begin
          x_q   <= x;
          y_q   <= y;
          ovf_q <= ovf;
        end
      end
    end
  end

endmodule

// File: rtl/rotator_pipe.sv
// Pipelined fixed-point 2-D rotator: ANGLE_W rotation stages (MSB first) plus a window register.
// Define ROTATOR_SATURATE_EN for clamping sums; default build wraps.
module rotator_pipe
  import rotator_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int ANGLE_W = 8,
  parameter int LIMIT   = 2 ** (WIDTH - 2)
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic signed [WIDTH-1:0] s_x,
  input  logic signed [WIDTH-1:0] s_y,
  input  logic [ANGLE_W-1:0]      s_angle,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic signed [WIDTH-1:0] m_x,
  output logic signed [WIDTH-1:0] m_y,
  output logic                    m_in_range,
  output logic                    m_ovf
);

  logic                    adv;
  logic                    vld_c [ANGLE_W+1];
  logic                    ovf_c [ANGLE_W+1];
  logic signed [WIDTH-1:0] x_c   [ANGLE_W+1];
  logic signed [WIDTH-1:0] y_c   [ANGLE_W+1];
  logic                    rot_c [ANGLE_W];
  logic [ANGLE_W-1:0]      ang_q [ANGLE_W-1];
  int                      ax, ay;

  // One global enable: a full output register with no taker freezes every stage.
  assign adv     = !m_valid || m_ready;
  assign s_ready = adv;

  assign vld_c[0] = s_valid;
  assign ovf_c[0] = 1'b0;
  assign x_c[0]   = s_x;
  assign y_c[0]   = s_y;

  // The angle travels alongside its sample so each stage sees its own bit.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int j = 0; j < ANGLE_W - 1; j++) ang_q[j] <= '0;
    end else if (adv) begin
      ang_q[0] <= s_angle;
      for (int j = 1; j < ANGLE_W - 1; j++) ang_q[j] <= ang_q[j-1];
    end
  end

  for (genvar i = 0; i < ANGLE_W; i++) begin : g_stage
    if (i == 0) begin : g_first
      assign rot_c[i] = s_angle[ANGLE_W-1];
    end else begin : g_rest
      assign rot_c[i] = ang_q[i-1][ANGLE_W-1-i];
    end

    rotator_stage #(
      .WIDTH (WIDTH),
      .STAGE (i)
    ) u_stage (
      .ACLK    (ACLK),
      .ARESETN (ARESETN),
      .en      (adv),
      .vld     (vld_c[i]),
      .rot     (rot_c[i]),
      .x       (x_c[i]),
      .y       (y_c[i]),
      .ovf     (ovf_c[i]),
      .vld_q   (vld_c[i+1]),
      .x_q     (x_c[i+1]),
      .y_q     (y_c[i+1]),
      .ovf_q   (ovf_c[i+1])
    );
  end

  // Magnitudes in int so the most negative code does not wrap.
  always_comb begin
    ax = x_c[ANGLE_W][WIDTH-1] ? -int'(x_c[ANGLE_W]) : int'(x_c[ANGLE_W]);
    ay = y_c[ANGLE_W][WIDTH-1] ? -int'(y_c[ANGLE_W]) : int'(y_c[ANGLE_W]);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      m_valid    <= 1'b0;
      m_x        <= '0;
      m_y        <= '0;
      m_in_range <= 1'b0;
      m_ovf      <= 1'b0;
    end else if (adv) begin
      m_valid <= vld_c[ANGLE_W];
      if (vld_c[ANGLE_W]) begin
        m_x        <= x_c[ANGLE_W];
        m_y        <= y_c[ANGLE_W];
        m_in_range <= (ax <= LIMIT) && (ay <= LIMIT);
        m_ovf      <= ovf_c[ANGLE_W];
      end
    end
  end

endmodule

// File: tb/tb_rotator_pipe.sv
// Directed bench for rotator_pipe (WIDTH=8, ANGLE_W=8, LIMIT=64).
// Expected values follow ROTATOR_SATURATE_EN when it is defined.
module tb_rotator_pipe;

  localparam int WIDTH   = 8;
  localparam int ANGLE_W = 8;
  localparam int LIMIT   = 64;

`ifdef ROTATOR_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic                    ACLK = 1'b0;
  logic                    ARESETN = 1'b0;
  logic                    s_valid = 1'b0;
  logic                    s_ready;
  logic signed [WIDTH-1:0] s_x = '0;
  logic signed [WIDTH-1:0] s_y = '0;
  logic [ANGLE_W-1:0]      s_angle = '0;
  logic                    m_valid;
  logic                    m_ready = 1'b1;
  logic signed [WIDTH-1:0] m_x;
  logic signed [WIDTH-1:0] m_y;
  logic                    m_in_range;
  logic                    m_ovf;

  int n_checks = 0;
  int n_errors = 0;

  // Hand-derived 8-bit stage constants for weights 1, 1/2, ... 1/128 rad.
  int cos_t [8] = '{69, 112, 124, 127, 127, 127, 127, 127};
  int sin_t [8] = '{108, 61, 32, 16, 8, 4, 2, 1};

  rotator_pipe #(.WIDTH(WIDTH), .ANGLE_W(ANGLE_W), .LIMIT(LIMIT)) dut (
    .ACLK       (ACLK),
    .ARESETN    (ARESETN),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_x        (s_x),
    .s_y        (s_y),
    .s_angle    (s_angle),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_x        (m_x),
    .m_y        (m_y),
    .m_in_range (m_in_range),
    .m_ovf      (m_ovf)
  );

  always #5 ACLK = ~ACLK;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int rnd(input int p);
    return (p + 64) >>> 7;
  endfunction

  function automatic int fit(input int v);
    if (v > 127)  return SAT ? 127 : v - 256;
    if (v < -128) return SAT ? -128 : v + 256;
    return v;
  endfunction

  function automatic void model(input int x, input int y, input int ang,
                                output int rx, output int ry, output int rr, output int ro);
    int cx, cy, px, py;
    cx = x; cy = y; ro = 0;
    for (int i = 0; i < ANGLE_W; i++) begin
      if (((ang >> (ANGLE_W - 1 - i)) & 1) == 1) begin
        px = rnd(cx * cos_t[i]) - rnd(cy * sin_t[i]);
        py = rnd(cx * sin_t[i]) + rnd(cy * cos_t[i]);
        if (px > 127 || px < -128 || py > 127 || py < -128) ro = 1;
        cx = fit(px);
        cy = fit(py);
      end
    end
    rx = cx; ry = cy;
    rr = ((cx < 0 ? -cx : cx) <= LIMIT && (cy < 0 ? -cy : cy) <= LIMIT) ? 1 : 0;
  endfunction

  // Send one sample, wait for it, check latency and results.
  task automatic run_vec(input string tag, input int x, input int y, input int ang,
                         input int ex, input int ey, input int er, input int eo);
    int lat;
    @(negedge ACLK);
    m_ready = 1'b1;
    s_x = WIDTH'(x); s_y = WIDTH'(y); s_angle = ANGLE_W'(ang); s_valid = 1'b1;
    #1;
    check_val({tag, ".s_ready"}, int'(s_ready), 1);
    @(negedge ACLK);
    s_valid = 1'b0;
    lat = 1;
    while (lat < 30 && !m_valid) begin
      @(negedge ACLK);
      lat++;
    end
    check_val({tag, ".latency"}, lat, ANGLE_W + 1);
    check_val({tag, ".m_x"}, int'(m_x), ex);
    check_val({tag, ".m_y"}, int'(m_y), ey);
    check_val({tag, ".in_range"}, int'(m_in_range), er);
    check_val({tag, ".ovf"}, int'(m_ovf), eo);
  endtask

  task automatic run_stream();
    int sent, rcvd, ex, ey, er, eo, sx, sy, sa;
    int qx[$], qy[$], qr[$], qo[$];
    bit vpipe [ANGLE_W+1];
    bit exp_mv, exp_adv;
    sent = 0; rcvd = 0;
    for (int k = 0; k <= ANGLE_W; k++) vpipe[k] = 1'b0;
    @(negedge ACLK);
    s_valid = 1'b0; m_ready = 1'b1;
    for (int cyc = 0; cyc < 120 && rcvd < 20; cyc++) begin
      @(negedge ACLK);
      m_ready = !((cyc >= 5 && cyc <= 8) || (cyc >= 14 && cyc <= 17));
      if (sent < 20) begin
        sx = ((sent * 53 + 17) % 256) - 128;
        sy = ((sent * 91 + 5) % 256) - 128;
        sa = (sent * 29 + 3) % 256;
        s_x = WIDTH'(sx); s_y = WIDTH'(sy); s_angle = ANGLE_W'(sa); s_valid = 1'b1;
      end else begin
        s_valid = 1'b0;
      end
      #1;
      exp_mv  = vpipe[ANGLE_W];
      exp_adv = !exp_mv || m_ready;
      check_val("stream.s_ready", int'(s_ready), int'(exp_adv));
      check_val("stream.m_valid", int'(m_valid), int'(exp_mv));
      if (m_valid && m_ready) begin
        if (qx.size() == 0) begin
          check_val("stream.unexpected_out", 1, 0);
        end else begin
          check_val("stream.m_x", int'(m_x), qx.pop_front());
          check_val("stream.m_y", int'(m_y), qy.pop_front());
          check_val("stream.in_range", int'(m_in_range), qr.pop_front());
          check_val("stream.ovf", int'(m_ovf), qo.pop_front());
        end
        rcvd++;
      end
      if (s_valid && exp_adv) begin
        model(sx, sy, sa, ex, ey, er, eo);
        qx.push_back(ex); qy.push_back(ey); qr.push_back(er); qo.push_back(eo);
        sent++;
      end
      if (exp_adv) begin
        for (int k = ANGLE_W; k > 0; k--) vpipe[k] = vpipe[k-1];
        vpipe[0] = s_valid;
      end
    end
    check_val("stream.received", rcvd, 20);
    check_val("stream.leftover", qx.size(), 0);
    s_valid = 1'b0;
    m_ready = 1'b1;
  endtask

  task automatic run_reset_flight();
    int seen;
    @(negedge ACLK);
    m_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge ACLK);
      s_x = WIDTH'(10 * k + 3); s_y = WIDTH'(-7 * k); s_angle = ANGLE_W'(k * 17); s_valid = 1'b1;
    end
    @(negedge ACLK);
    s_valid = 1'b0;
    repeat (4) @(negedge ACLK);
    check_val("rst.pre_m_valid", int'(m_valid), 1);
    #2 ARESETN = 1'b0;
    #1;
    check_val("rst.m_valid", int'(m_valid), 0);
    check_val("rst.m_x", int'(m_x), 0);
    check_val("rst.m_y", int'(m_y), 0);
    check_val("rst.m_ovf", int'(m_ovf), 0);
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    seen = 0;
    repeat (15) begin
      @(negedge ACLK);
      if (m_valid) seen++;
    end
    check_val("rst.ghost_outputs", seen, 0);
    run_vec("post_rst", 64, 0, 'h40, 56, 31, 1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check_val("reset.m_valid", int'(m_valid), 0);
    check_val("reset.m_x", int'(m_x), 0);
    check_val("reset.m_y", int'(m_y), 0);
    check_val("reset.in_range", int'(m_in_range), 0);
    check_val("reset.ovf", int'(m_ovf), 0);
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    m_ready = 1'b0;
    #1;
    check_val("reset.s_ready", int'(s_ready), 1);

    run_vec("zero",    64,   0,   'h00, 64,  0,   1, 0);
    run_vec("half",    64,   0,   'h40, 56,  31,  1, 0);
    run_vec("ovf",     127,  127, 'h20, 91,  SAT ? 127 : -101, 0, 1);
    run_vec("sticky",  127,  127, 'h30, SAT ? 74 : 103, SAT ? 127 : -89, 0, 1);
    run_vec("one_rad", 0,    64,  'h80, -54, 35,  1, 0);
    run_vec("multi",   100,  -50, 'hC0, 57,  96,  0, 0);
    run_vec("edge64",  64,   -64, 'h00, 64,  -64, 1, 0);
    run_vec("edge65",  65,   0,   'h00, 65,  0,   0, 0);
    run_vec("neg_max", -128, 0,   'h00, -128, 0,  0, 0);

    run_stream();
    run_reset_flight();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rotator_pipe.md
Name: rotator_pipe

Overview:
- Pipelined, parametrised 2-D fixed-point rotator: rotates (x, y) by a binary-weighted angle, one rotation stage per angle bit, plus an output window check.
- Successor to the single-cycle 8-bit rotator; adds generic width, angle resolution and window limit, valid/ready flow control, per-sample overflow reporting and a fixed pipeline latency.
- Sits between the coordinate generator and the pixel/plot stage of the graphics path.

Parameters:
- WIDTH, 8, coordinate width, signed two's complement, Q1.(WIDTH-1) coefficient format; legal 6..16.
- ANGLE_W, 8, angle width; unsigned radians; MSB weight 1 rad, bit k weight 2^(k-ANGLE_W+1) rad; legal 2..16.
- LIMIT, 2^(WIDTH-2), window half-size; a sample is in range iff |x| <= LIMIT and |y| <= LIMIT.

Ports:
- ACLK  in  1  clock, all logic on rising edge
- ARESETN  in  1  asynchronous active-low reset
- s_valid  in  1  input sample valid
- s_ready  out  1  block can accept a sample
- s_x  in  WIDTH  input x, signed
- s_y  in  WIDTH  input y, signed
- s_angle  in  ANGLE_W  rotation angle
- m_valid  out  1  output sample valid
- m_ready  in  1  downstream accepts
- m_x  out  WIDTH  rotated x
- m_y  out  WIDTH  rotated y
- m_in_range  out  1  both outputs inside window
- m_ovf  out  1  at least one stage overflowed for this sample

Behaviour:
- Reset (ARESETN low, async): all stage valid bits, m_valid, m_x, m_y, m_in_range, m_ovf = 0; s_ready = 1 after release. Reset mid-flight discards all in-flight samples; nothing is emitted after release until new input.
- Transfer: input on s_valid && s_ready; output on m_valid && m_ready.
- Pipeline: ANGLE_W rotation stages (stage i handles angle bit ANGLE_W-1-i, MSB first) + 1 output/window register; latency exactly ANGLE_W+1 cycles with m_ready held high; throughput 1 sample/cycle.
- Stall: global enable adv = !m_valid || m_ready; s_ready = adv (combinational). When adv = 0 every stage holds data and valid bits. Bubbles are not compressed.
- Stage with angle bit 0: passes x, y, ovf unchanged. Bit 1: x' = xc - ys, y' = xs + yc using stage constants c = cos(w), s = sin(w).
- Constants: round(2^(WIDTH-1) * value), clipped to 2^(WIDTH-1)-1; all constants non-negative.
- Products: full 2*WIDTH-bit signed product, arithmetic right shift by WIDTH-1 with round-half-up (add 2^(WIDTH-2) before shift); sum computed at WIDTH+1 bits.
- Overflow: sum outside signed WIDTH range sets the sample's ovf bit (sticky through the remaining stages); result handling per Optional Feature.
- Window: uses magnitudes at WIDTH+1 bits, so the most negative input (-2^(WIDTH-1)) is handled without wrap; m_in_range = (|x| <= LIMIT) && (|y| <= LIMIT). Unlike the predecessor, both axes are always checked.
- m_x, m_y hold their last value when m_valid = 0.

Optional Feature:
- ROTATOR_SATURATE_EN defined: overflowing sums clamp to +2^(WIDTH-1)-1 or -2^(WIDTH-1).
- Not defined: sums wrap (truncate to WIDTH bits).
- m_ovf is reported in both builds.

Decomposition:
- Package rotator_pkg: Q1.15 sin/cos constant tables for weights 2^0..2^-15 rad, a function rescaling a table entry to WIDTH (round, clip), and the rounding/saturation helper function.
- One sub-module, rotator_stage (params WIDTH, STAGE): a single registered rotation stage with valid, ovf and enable; the top generates ANGLE_W instances plus the window register.

Test Plan (WIDTH=8, ANGLE_W=8, LIMIT=64, m_ready=1 unless stated):
- Reset, then s_x=64, s_y=0, s_angle=0x00 -> after 9 cycles m_x=64, m_y=0, m_in_range=1, m_ovf=0.
- s_x=64, s_y=0, s_angle=0x40 (0.5 rad, c=112, s=61) -> m_x=56, m_y=31, m_in_range=1, m_ovf=0.
- s_x=127, s_y=127, s_angle=0x20 (c=124, s=32) -> m_x=91, m_ovf=1, m_in_range=0; m_y=127 with ROTATOR_SATURATE_EN, -101 without.
- Stream 20 back-to-back samples, m_ready low for cycles 5-8 -> s_ready low exactly while m_valid && !m_ready; no sample lost, duplicated or reordered versus the reference model.
- Assert ARESETN low with 5 samples in flight -> m_valid=0 immediately; after release no output appears until new input, and the first new sample arrives 9 cycles after acceptance.
- s_x=-128, s_y=0, s_angle=0 -> m_x=-128, m_in_range=0, m_ovf=0.
